// File: rtl/multi_adder_pkg.sv
// Shared types and width helper for the multi_adder accumulator family.
package multi_adder_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_t;

    // Operand width of a lookahead adder with the given group size and depth.
    function automatic int cla_width(input int n, input int levels);
        return n ** levels;
    endfunction

    localparam int CLA_DEFAULT_W = cla_width(4, 2);

endpackage

// File: rtl/carrylookahead_adder.sv
// Multi-level carry-lookahead adder: W = N**LEVELS bits, groups of N at each level.
module carrylookahead_adder
    import multi_adder_pkg::*;
#(
    parameter int N      = 4,
    parameter int LEVELS = 2,
    localparam int W     = cla_width(N, LEVELS)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    // Level 0 holds per-bit generate/propagate; level l holds W/N**l group terms.
    logic [W-1:0] g [0:LEVELS];
    logic [W-1:0] p [0:LEVELS];
    logic [W-1:0] c [0:LEVELS];

    always_comb begin
        // NOTE: every variable gets a default before the loops so no path leaves it unassigned, which would infer a latch.
        g = '{default: '0};
        p = '{default: '0};
        c = '{default: '0};
        g[0] = a & b;
        p[0] = a ^ b;

        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < W / (N ** l); j++) begin
                p[l][j] = 1'b1;
                for (int k = 0; k < N; k++) begin
                    g[l][j] = g[l-1][j*N+k] | (p[l-1][j*N+k] & g[l][j]);
                    p[l][j] = p[l][j] & p[l-1][j*N+k];
                end
            end
        end

        // Carries flow top-down: each group's carry-in seeds its N children.
        c[LEVELS][0] = c_in;
        for (int l = LEVELS; l >= 1; l--) begin
            for (int j = 0; j < W / (N ** l); j++) begin
                for (int k = 0; k < N; k++) begin
                    if (k == 0) begin
                        c[l-1][j*N] = c[l][j];
                    end else begin
                        c[l-1][j*N+k] = g[l-1][j*N+k-1] | (p[l-1][j*N+k-1] & c[l-1][j*N+k-1]);
                    end
                end
            end
        end

        sum   = p[0] ^ c[0];
        c_out = g[LEVELS][0] | (p[LEVELS][0] & c_in);
    end

endmodule

// File: rtl/cla_stream_accumulator.sv
// Packet accumulator over a valid/ready stream, summing through one lookahead adder.
// Optional build macro ACC_SATURATE_EN clamps the running sum at all-ones on carry-out.
module cla_stream_accumulator
    import multi_adder_pkg::*;
#(
    parameter int N      = 4,
    parameter int LEVELS = 2,
    parameter int CNT_W  = 8,
    localparam int W     = cla_width(N, LEVELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state;
    logic [W-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     raw_sum;
    logic             carry;
    logic [W-1:0]     acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;

    carrylookahead_adder #(.N(N), .LEVELS(LEVELS)) u_adder (
        .a     (acc),
        .b     (in_data),
        .c_in  (1'b0),
        .sum   (raw_sum),
        .c_out (carry)
    );

`ifdef ACC_SATURATE_EN
    // An all-ones accumulator carries out on any non-zero operand, so it stays clamped.
    assign acc_next = carry ? '1 : raw_sum;
`else
    assign acc_next = raw_sum;
`endif
    assign ovf_next = ovf | carry;
    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_sum   <= acc_next;
                            out_ovf   <= ovf_next;
                            out_count <= cnt_next;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            ovf       <= 1'b0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            acc <= acc_next;
                            ovf <= ovf_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_stream_accumulator.sv
// Directed and randomized bench for cla_stream_accumulator (CNT_W=2 to reach count saturation).
module tb_cla_stream_accumulator;

    localparam int N      = 4;
    localparam int LEVELS = 2;
    localparam int W      = 16;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cla_stream_accumulator #(.N(N), .LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packet result from the arithmetic definition: true sum, then wrap or clamp.
    function automatic void model(input logic [W-1:0] q[$], output logic [W-1:0] s,
                                  output logic o, output logic [CNT_W-1:0] c);
        longint total = 0;
        longint maxc  = (64'd1 << CNT_W) - 1;
        foreach (q[i]) total += longint'(q[i]);
        o = (total > 64'hFFFF);
`ifdef ACC_SATURATE_EN
        s = o ? 16'hFFFF : total[W-1:0];
`else
        s = total[W-1:0];
`endif
        c = (q.size() > maxc) ? CNT_W'(maxc) : CNT_W'(q.size());
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic drive_beat(input logic [W-1:0] d, input logic last, input int idle);
        int n = 0;
        repeat (idle) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (n == 32) chk("in_ready_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] s, input logic o,
                                 input logic [CNT_W-1:0] c, input int hold);
        int n = 0;
        while (out_valid !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (n == 32) chk({tag, "_valid_timeout"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_ovf"}, out_ovf, o);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_in_ready_hold"}, in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_stable_sum"}, out_sum, s);
            chk({tag, "_stable_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic run_packet(input string tag, input logic [W-1:0] q[$], input int hold,
                              input int max_idle);
        logic [W-1:0]     s;
        logic             o;
        logic [CNT_W-1:0] c;
        foreach (q[i]) drive_beat(q[i], (i == q.size() - 1), $urandom_range(0, max_idle));
        model(q, s, o, c);
        expect_result(tag, s, o, c, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pkt[$];
        logic [W-1:0] got[$];
        logic [W-1:0] bb [4];
        logic         lst[4];
        logic         r;
        int           idx;
        int           zeros;
        int           cyc;
        int           n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Three-beat packet with out_ready held high: result valid for exactly one cycle.
        out_ready = 1'b1;
        drive_beat(16'h0001, 1'b0, 0);
        drive_beat(16'h0002, 1'b0, 0);
        drive_beat(16'h0003, 1'b1, 0);
        expect_result("p3", 16'h0006, 1'b0, 2'd3, 0);

        // Overflow packet.
        drive_beat(16'hFFFF, 1'b0, 0);
        drive_beat(16'h0002, 1'b1, 0);
`ifdef ACC_SATURATE_EN
        expect_result("ovf", 16'hFFFF, 1'b1, 2'd2, 0);
`else
        expect_result("ovf", 16'h0001, 1'b1, 2'd2, 0);
`endif

        // Backpressure: held result stays stable and a waiting beat is not consumed.
        drive_beat(16'h1234, 1'b1, 0);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 16'h1234);
            chk("bp_count", out_count, 1);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("bp_next", 16'h1111, 1'b0, 2'd1, 0);

        // Beat counter saturation.
        pkt = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        run_packet("cnt_sat", pkt, 0, 0);
        chk("cnt_sat_direct", out_count, 3);

        // Reset mid-packet discards the partial sum and count.
        drive_beat(16'h0010, 1'b0, 0);
        drive_beat(16'h0020, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_beat(16'h0005, 1'b1, 0);
        expect_result("rst_mid", 16'h0005, 1'b0, 2'd1, 0);

        // Reset during HOLD drops the held result without a handshake.
        drive_beat(16'hABCD, 1'b1, 0);
        chk("rst_hold_pre_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_sum", out_sum, 0);
        chk("rst_hold_in_ready", in_ready, 1);
        rst = 1'b0;

        // Back-to-back packets with in_valid held high: one dead input cycle between them.
        bb    = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        lst   = '{1'b0, 1'b1, 1'b0, 1'b1};
        idx   = 0;
        zeros = 0;
        cyc   = 0;
        out_ready = 1'b1;
        while (idx < 4 && cyc < 40) begin
            in_valid = 1'b1;
            in_data  = bb[idx];
            in_last  = lst[idx];
            r = in_ready;
            if (out_valid === 1'b1) got.push_back(out_sum);
            if (r !== 1'b1) zeros++;
            @(negedge clk);
            if (r === 1'b1) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        got.push_back(out_sum);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_beats", idx, 4);
        chk("b2b_dead_cycles", zeros, 1);
        chk("b2b_results", got.size(), 2);
        chk("b2b_sum0", (got.size() > 0) ? got[0] : 16'hDEAD, 16'h0300);
        chk("b2b_sum1", (got.size() > 1) ? got[1] : 16'hDEAD, 16'h0700);

        // Randomized packets against the arithmetic model.
        for (int p = 0; p < 24; p++) begin
            int len = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pkt.push_back(W'($urandom_range(16'hC000, 16'hFFFF)));
                else pkt.push_back(W'($urandom_range(0, 16'h0FFF)));
            end
            run_packet($sformatf("rnd%0d", p), pkt, $urandom_range(0, 3), 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
